decode_queue: RTL and testbench

//  Registered successor to the combinational ID decoder. Decodes RV32I instructions, plus RV32M when enabled.

---
 rtl/decode_queue_if.sv | 45 ++++
 rtl/decode_queue.sv | 184 ++++++++++++++++++
 tb/tb_decode_queue.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Handshake and decoded-field bundle between the IF/ID register, the decode queue and ID/EX.
interface decode_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       imm;
  logic              imm_en;
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic [7:0]        funct7;
  logic [4:0]        rd_addr;
  logic              rd_en;
  logic [4:0]        rs1_addr;
  logic              rs1_en;
  logic [4:0]        rs2_addr;
  logic              rs2_en;
  logic [4:0]        mem_op;
  logic              jump_en;
  logic              muldiv;
  logic              illegal;
  logic [LVL_W-1:0]  level;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, imm, imm_en, op, funct3, funct7,
           rd_addr, rd_en, rs1_addr, rs1_en, rs2_addr, rs2_en, mem_op,
           jump_en, muldiv, illegal, level
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, imm, imm_en, op, funct3, funct7,
           rd_addr, rd_en, rs1_addr, rs1_en, rs2_addr, rs2_en, mem_op,
           jump_en, muldiv, illegal, level
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I(+M) decoder feeding a DEPTH-entry FIFO of decoded bundles; fields come straight
// from the head entry register, so an instruction pushed at one edge is visible after it.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter bit          EN_M  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [4:0]  MEM_NONE = 5'b00111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic        imm_en;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [7:0]  funct7;
    logic [4:0]  rd_addr;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic        rs1_en;
    logic [4:0]  rs2_addr;
    logic        rs2_en;
    logic [4:0]  mem_op;
    logic        jump_en;
    logic        muldiv;
    logic        illegal;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           dec_c;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_c, pop_c, in_ready_c, out_valid_c;
  logic [31:0]      ins;
  logic             rd_nz, rs1_nz;

  assign ins    = bus.in_instr;
  assign rd_nz  = (ins[11:7] != 5'd0);
  assign rs1_nz = (ins[19:15] != 5'd0);

  // Instruction decode; illegal encodings are still queued so the trap stays in order.
  always_comb begin
    dec_c          = '0;
    dec_c.pc       = bus.in_pc;
    dec_c.op       = ins[6:0];
    dec_c.funct3   = ins[14:12];
    dec_c.funct7   = {1'b0, ins[31:25]};
    dec_c.rd_addr  = ins[11:7];
    dec_c.rs1_addr = ins[19:15];
    dec_c.rs2_addr = ins[24:20];
    dec_c.mem_op   = MEM_NONE;
    unique case (ins[6:0])
      7'b0110011: begin
        dec_c.rd_en  = rd_nz;
        dec_c.rs1_en = rs1_nz;
        dec_c.rs2_en = 1'b1;
        if (ins[31:25] == 7'b0000001) begin
          if (EN_M) dec_c.muldiv  = 1'b1;
          else      dec_c.illegal = 1'b1;
        end
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_c.imm     = {{20{ins[31]}}, ins[31:20]};
        dec_c.imm_en  = 1'b1;
        dec_c.rd_en   = rd_nz;
        dec_c.rs1_en  = rs1_nz;
        dec_c.jump_en = (ins[6:0] == 7'b1100111);
        if (ins[6:0] == 7'b0000011) begin
          if (ins[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
            dec_c.mem_op = {1'b0, 1'b1, ins[14:12]};
          else
            dec_c.illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec_c.imm    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec_c.imm_en = 1'b1;
        dec_c.rs1_en = rs1_nz;
        dec_c.rs2_en = 1'b1;
        if (ins[14:12] inside {3'b000, 3'b001, 3'b010})
          dec_c.mem_op = {1'b1, 1'b0, ins[14:12]};
        else
          dec_c.illegal = 1'b1;
      end
      7'b1100011: begin
        dec_c.imm     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        dec_c.imm_en  = 1'b1;
        dec_c.rs1_en  = rs1_nz;
        dec_c.rs2_en  = 1'b1;
        dec_c.jump_en = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec_c.imm    = {ins[31:12], 12'd0};
        dec_c.imm_en = 1'b1;
        dec_c.rd_en  = rd_nz;
      end
      7'b1101111: begin
        dec_c.imm     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        dec_c.imm_en  = 1'b1;
        dec_c.rd_en   = rd_nz;
        dec_c.jump_en = 1'b1;
      end
      7'b0001111, 7'b1110011: ;
      default: dec_c.illegal = 1'b1;
    endcase
    if (dec_c.illegal) begin
      dec_c.imm_en  = 1'b0;
      dec_c.rd_en   = 1'b0;
      dec_c.rs1_en  = 1'b0;
      dec_c.rs2_en  = 1'b0;
      dec_c.jump_en = 1'b0;
      dec_c.muldiv  = 1'b0;
      dec_c.mem_op  = MEM_NONE;
    end
  end

  assign in_ready_c  = (level_q != LVL_W'(DEPTH));
  assign out_valid_c = (level_q != '0);
  assign push_c      = bus.in_valid & in_ready_c;
  assign pop_c       = out_valid_c & bus.out_ready;

  // Pointer/occupancy update; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
      else if (pop_c && !push_c) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c && !bus.flush) begin
      mem_q[wr_ptr_q] <= dec_c;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.level     = level_q;
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign bus.imm       = mem_q[rd_ptr_q].imm;
  assign bus.imm_en    = mem_q[rd_ptr_q].imm_en;
  assign bus.op        = mem_q[rd_ptr_q].op;
  assign bus.funct3    = mem_q[rd_ptr_q].funct3;
  assign bus.funct7    = mem_q[rd_ptr_q].funct7;
  assign bus.rd_addr   = mem_q[rd_ptr_q].rd_addr;
  assign bus.rd_en     = mem_q[rd_ptr_q].rd_en;
  assign bus.rs1_addr  = mem_q[rd_ptr_q].rs1_addr;
  assign bus.rs1_en    = mem_q[rd_ptr_q].rs1_en;
  assign bus.rs2_addr  = mem_q[rd_ptr_q].rs2_addr;
  assign bus.rs2_en    = mem_q[rd_ptr_q].rs2_en;
  assign bus.mem_op    = mem_q[rd_ptr_q].mem_op;
  assign bus.jump_en   = mem_q[rd_ptr_q].jump_en;
  assign bus.muldiv    = mem_q[rd_ptr_q].muldiv;
  assign bus.illegal   = mem_q[rd_ptr_q].illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one EN_M=0 and one EN_M=1 instance share the same stimulus.
module tb_decode_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  decode_queue_if #(.DEPTH(4)) ifa ();
  decode_queue_if #(.DEPTH(4)) ifm ();

  decode_queue #(.DEPTH(4), .EN_M(1'b0)) dut   (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  decode_queue #(.DEPTH(4), .EN_M(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));

  assign ifm.flush     = ifa.flush;
  assign ifm.in_valid  = ifa.in_valid;
  assign ifm.in_instr  = ifa.in_instr;
  assign ifm.in_pc     = ifa.in_pc;
  assign ifm.out_ready = ifa.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one instruction for exactly one rising edge.
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    ifa.in_instr = instr;
    ifa.in_pc    = pc;
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic pop();
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b1;
    ifa.flush     = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_instr  = '0;
    ifa.in_pc     = '0;
    ifa.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_level", ifa.level, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_imm", ifa.imm, 0);
    chk("rst_mem_op", ifa.mem_op, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    push(32'h0050_0093, 32'h100);
    chk("addi_valid", ifa.out_valid, 1);
    chk("addi_level", ifa.level, 1);
    chk("addi_imm", ifa.imm, 5);
    chk("addi_imm_en", ifa.imm_en, 1);
    chk("addi_rd_en", ifa.rd_en, 1);
    chk("addi_rd_addr", ifa.rd_addr, 1);
    chk("addi_rs1_en", ifa.rs1_en, 0);
    chk("addi_mem_op", ifa.mem_op, 5'b00111);
    chk("addi_pc", ifa.out_pc, 32'h100);
    pop();
    chk("pop_valid", ifa.out_valid, 0);
    chk("pop_level", ifa.level, 0);

    // SW x2,8(x1)
    push(32'h0020_A423, 32'h104);
    chk("sw_imm", ifa.imm, 8);
    chk("sw_rs1_en", ifa.rs1_en, 1);
    chk("sw_rs2_en", ifa.rs2_en, 1);
    chk("sw_rd_en", ifa.rd_en, 0);
    chk("sw_mem_op", ifa.mem_op, 5'b10010);
    pop();

    // LW x3,4(x1)
    push(32'h0040_A183, 32'h108);
    chk("lw_imm", ifa.imm, 4);
    chk("lw_mem_op", ifa.mem_op, 5'b01010);
    chk("lw_rd_en", ifa.rd_en, 1);
    pop();

    // LOAD with funct3=011
    push(32'h0000_B083, 32'h10C);
    chk("badld_illegal", ifa.illegal, 1);
    chk("badld_mem_op", ifa.mem_op, 5'b00111);
    chk("badld_rd_en", ifa.rd_en, 0);
    chk("badld_imm_en", ifa.imm_en, 0);
    pop();

    push(32'hFFFF_FFFF, 32'h110);
    chk("ff_illegal", ifa.illegal, 1);
    chk("ff_imm_en", ifa.imm_en, 0);
    chk("ff_rd_en", ifa.rd_en, 0);
    chk("ff_rs1_en", ifa.rs1_en, 0);
    chk("ff_rs2_en", ifa.rs2_en, 0);
    chk("ff_jump_en", ifa.jump_en, 0);
    chk("ff_mem_op", ifa.mem_op, 5'b00111);
    pop();

    // MUL x3,x1,x2
    push(32'h0220_81B3, 32'h114);
    chk("mul_nom_illegal", ifa.illegal, 1);
    chk("mul_nom_rd_en", ifa.rd_en, 0);
    chk("mul_nom_muldiv", ifa.muldiv, 0);
    chk("mul_m_muldiv", ifm.muldiv, 1);
    chk("mul_m_rd_en", ifm.rd_en, 1);
    chk("mul_m_illegal", ifm.illegal, 0);
    chk("mul_m_funct7", ifm.funct7, 8'h01);
    pop();

    // BEQ x1,x2,-4
    push(32'hFE20_8EE3, 32'h118);
    chk("beq_imm", ifa.imm, 32'hFFFF_FFFC);
    chk("beq_jump_en", ifa.jump_en, 1);
    chk("beq_rs1_en", ifa.rs1_en, 1);
    chk("beq_rs2_en", ifa.rs2_en, 1);
    chk("beq_rd_en", ifa.rd_en, 0);
    pop();

    // JAL x0,8: rd masked for x0
    push(32'h0080_006F, 32'h11C);
    chk("jal_imm", ifa.imm, 8);
    chk("jal_jump_en", ifa.jump_en, 1);
    chk("jal_rd_en", ifa.rd_en, 0);
    pop();

    // LUI x5,0x12345
    push(32'h1234_52B7, 32'h120);
    chk("lui_imm", ifa.imm, 32'h1234_5000);
    chk("lui_rd_en", ifa.rd_en, 1);
    chk("lui_rd_addr", ifa.rd_addr, 5);
    chk("lui_rs1_en", ifa.rs1_en, 0);
    pop();

    // Fill to DEPTH with consumer stalled: ADDI x1,x0,i
    ifa.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ifa.in_instr = (32'(i) << 20) | 32'h93;
      ifa.in_pc    = 32'h200 + 32'(4 * i);
      @(negedge clk);
    end
    chk("full_level", ifa.level, 4);
    chk("full_in_ready", ifa.in_ready, 0);
    chk("full_head_imm", ifa.imm, 1);
    ifa.in_instr = (32'd5 << 20) | 32'h93;
    ifa.in_pc    = 32'h214;
    @(negedge clk);
    chk("full_hold_level", ifa.level, 4);
    ifa.out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_level", ifa.level, 3);
    chk("full_pop_head", ifa.imm, 2);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("pushpop_level", ifa.level, 3);
    chk("pushpop_head", ifa.imm, 3);
    @(negedge clk);
    chk("drain_head4", ifa.imm, 4);
    @(negedge clk);
    chk("drain_head5", ifa.imm, 5);
    chk("drain_pc5", ifa.out_pc, 32'h214);
    @(negedge clk);
    ifa.out_ready = 1'b0;
    chk("drain_valid", ifa.out_valid, 0);
    chk("drain_level", ifa.level, 0);

    // Flush with a same-cycle push
    push(32'h0010_0093, 32'h300);
    push(32'h0020_0093, 32'h304);
    push(32'h0030_0093, 32'h308);
    chk("preflush_level", ifa.level, 3);
    ifa.in_instr = 32'hFFFF_F0B7;
    ifa.in_pc    = 32'h30C;
    ifa.in_valid = 1'b1;
    ifa.flush    = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifa.flush    = 1'b0;
    chk("flush_level", ifa.level, 0);
    chk("flush_valid", ifa.out_valid, 0);
    chk("flush_in_ready", ifa.in_ready, 1);
    push(32'h0070_0093, 32'h310);
    chk("postflush_level", ifa.level, 1);
    chk("postflush_imm", ifa.imm, 7);
    chk("postflush_pc", ifa.out_pc, 32'h310);
    pop();

    // Asynchronous reset mid-operation
    push(32'h0050_0093, 32'h400);
    push(32'h0060_0093, 32'h404);
    chk("prerst_level", ifa.level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ifa.out_valid, 0);
    chk("arst_level", ifa.level, 0);
    chk("arst_imm", ifa.imm, 0);
    chk("arst_pc", ifa.out_pc, 0);
    chk("arst_rd_en", ifa.rd_en, 0);
    chk("arst_op", ifa.op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
